fetch_ctrl: RTL and testbench

Instruction-fetch sequencer between the debounced step button and the instruction ROM. Owns the PC, drives the ROM word address, waits out the ROM read latency, and presents the fetched word to a downstream consumer (LED display mux or decode stage) over a valid/ready handshake. Fetches run one at a time on each button release or continuously in run mode. The PC can be overwritten (jump/restart) at any time.

---
 rtl/fetch_ctrl_pkg.sv | 19 +
 rtl/fetch_ctrl_step_edge.sv | 19 +
 rtl/fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_fetch_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// word size, legal ROM latency range and a PC alignment helper.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int WORD_BYTES  = 4;
  localparam int ROM_LAT_MIN = 1;
  localparam int ROM_LAT_MAX = 3;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_step_edge.sv
// Registered button level plus falling-edge pulse. The register clears to 0,
// so a button already held down when reset lifts produces no edge.
module step_edge (
  input  logic Clk,
  input  logic Rst,
  input  logic Btn,
  output logic Fall
);

  logic btn_d;

  always_ff @(posedge Clk) begin
    if (!Rst) btn_d <= 1'b0;
    else      btn_d <= Btn;
  end

  assign Fall = btn_d & ~Btn;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, waits out the ROM latency and
// presents each fetched word to a consumer over a valid/ready handshake.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int          ROM_LAT  = 1,
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Step,
  input  logic              Run,
  input  logic              Load,
  input  logic [31:0]       Load_addr,
  output logic [ADDR_W-1:0] Rom_addr,
  input  logic [31:0]       Rom_data,
  output logic [31:0]       Inst,
  output logic              Inst_valid,
  input  logic              Inst_ready,
  output logic [31:0]       PC,
  output logic              Busy,
  output logic [1:0]        Dbg_state
);

  // Counter reload: the last FETCH cycle is the one where the count reads 0.
  localparam logic [1:0] LAT_INIT = 2'(ROM_LAT - 1);

  state_t      state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  logic [31:0] pc_q, pc_nx;
  logic [31:0] inst_q, inst_nx;
  logic        pending, pending_nx;
  logic        clr_pend;
  logic        busy_q;
  logic        step_fall;
  logic        want;

  step_edge u_step_edge (
    .Clk  (Clk),
    .Rst  (Rst),
    .Btn  (Step),
    .Fall (step_fall)
  );

  assign want = pending | Run;

  // Handshake: Inst_valid is high only in HOLD, where Inst is frozen; a word
  // transfers on any rising edge with Inst_valid & Inst_ready. A Load in HOLD
  // ends the hold regardless, counting as a transfer only if Inst_ready is up.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pc_nx    = pc_q;
    inst_nx  = inst_q;
    clr_pend = 1'b0;
    case (state)
      IDLE: begin
        if (Load) begin
          pc_nx = word_align(Load_addr);
        end else if (want) begin
          state_nx = FETCH;
          cnt_nx   = LAT_INIT;
          clr_pend = 1'b1;
        end
      end
      FETCH: begin
        if (Load) begin
          pc_nx  = word_align(Load_addr);
          cnt_nx = LAT_INIT;
        end else if (cnt == 2'd0) begin
          inst_nx  = Rom_data;
          state_nx = HOLD;
        end else begin
          cnt_nx = cnt - 2'd1;
        end
      end
      HOLD: begin
        if (Load || Inst_ready) begin
          pc_nx = Load ? word_align(Load_addr) : pc_q + 32'(WORD_BYTES);
          if (want) begin
            state_nx = FETCH;
            cnt_nx   = LAT_INIT;
            clr_pend = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // A fresh edge wins over the clear so a request arriving on the
    // launch cycle is not lost.
    pending_nx = step_fall | (pending & ~clr_pend);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      pending <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pc_q    <= pc_nx;
      inst_q  <= inst_nx;
      pending <= pending_nx;
      busy_q  <= (state_nx != IDLE);
    end
  end

  assign Rom_addr   = pc_q[ADDR_W+1:2];
  assign PC         = pc_q;
  assign Inst       = inst_q;
  assign Inst_valid = (state == HOLD);
  assign Busy       = busy_q;
  assign Dbg_state  = state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: one instance at ROM_LAT=1 and one at
// ROM_LAT=2, driven by the same inputs, each fed by its own ROM model.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic        Clk;
  logic        Rst;
  logic        Step;
  logic        Run;
  logic        Load;
  logic [31:0] Load_addr;
  logic        Inst_ready;

  logic [5:0]  rom_addr1, rom_addr2, addr2_d;
  logic [31:0] rom_data1, rom_data2;
  logic [31:0] inst1, inst2, pc1, pc2;
  logic        valid1, valid2, busy1, busy2;
  logic [1:0]  st1, st2;

  logic [31:0] rom [64];
  int total = 0;
  int bad   = 0;

  fetch_ctrl #(.ROM_LAT(1), .ADDR_W(6), .RESET_PC(32'h0)) u_lat1 (
    .Clk(Clk), .Rst(Rst), .Step(Step), .Run(Run), .Load(Load),
    .Load_addr(Load_addr), .Rom_addr(rom_addr1), .Rom_data(rom_data1),
    .Inst(inst1), .Inst_valid(valid1), .Inst_ready(Inst_ready),
    .PC(pc1), .Busy(busy1), .Dbg_state(st1)
  );

  fetch_ctrl #(.ROM_LAT(2), .ADDR_W(6), .RESET_PC(32'h0)) u_lat2 (
    .Clk(Clk), .Rst(Rst), .Step(Step), .Run(Run), .Load(Load),
    .Load_addr(Load_addr), .Rom_addr(rom_addr2), .Rom_data(rom_data2),
    .Inst(inst2), .Inst_valid(valid2), .Inst_ready(Inst_ready),
    .PC(pc2), .Busy(busy2), .Dbg_state(st2)
  );

  // Clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ROM models: latency 1 reads combinationally, latency 2 through one address register.
  assign rom_data1 = rom[rom_addr1];
  always @(posedge Clk) addr2_d <= rom_addr2;
  assign rom_data2 = rom[addr2_d];

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 | (32'(i) << 8) | 32'(i);
    rom[0] = 32'h2001_0005;

    // Reset with the button held down.
    Rst = 1'b0; Step = 1'b1; Run = 1'b0; Load = 1'b0;
    Load_addr = 32'h0; Inst_ready = 1'b0;
    @(negedge Clk);
    tick(); tick(); tick();
    Rst = 1'b1;
    tick(); tick();
    chk("rst_pc",    pc1, 32'h0);
    chk("rst_inst",  inst1, 32'h0);
    chk("rst_valid", 32'(valid1), 32'h0);
    chk("rst_busy",  32'(busy1), 32'h0);
    chk("rst_state", 32'(st1), 32'(IDLE));

    // Single step at ROM_LAT=1, consumer stalled.
    Step = 1'b0;
    tick();
    chk("l1_edge_busy", 32'(busy1), 32'h0);
    Step = 1'b1;
    tick();
    chk("l1_fetch_valid", 32'(valid1), 32'h0);
    chk("l1_fetch_busy",  32'(busy1), 32'h1);
    tick();
    chk("l1_valid", 32'(valid1), 32'h1);
    chk("l1_inst",  inst1, 32'h2001_0005);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("l1_hold_valid", 32'(valid1), 32'h1);
      chk("l1_hold_inst",  inst1, 32'h2001_0005);
      chk("l1_hold_pc",    pc1, 32'h0);
    end
    Inst_ready = 1'b1;
    tick();
    Inst_ready = 1'b0;
    chk("l1_xfer_pc",    pc1, 32'h4);
    chk("l1_xfer_state", 32'(st1), 32'(IDLE));
    chk("l1_xfer_valid", 32'(valid1), 32'h0);

    Rst = 1'b0; tick(); Rst = 1'b1; tick();

    // Run mode at ROM_LAT=2: one word every 3 cycles, crossing the ROM wrap.
    Run = 1'b1; Inst_ready = 1'b1;
    tick();
    for (int k = 0; k <= 64; k++) begin
      tick(); tick();
      chk("run_valid", 32'(valid2), 32'h1);
      chk("run_inst",  inst2, rom[k % 64]);
      chk("run_pc",    pc2, 32'(4 * k));
      chk("run_addr",  32'(rom_addr2), 32'(k % 64));
      tick();
      chk("run_gap_valid", 32'(valid2), 32'h0);
      chk("run_next_pc",   pc2, 32'(4 * (k + 1)));
    end

    // Run drops mid-fetch: the word is still delivered and held.
    Run = 1'b0; Inst_ready = 1'b0;
    tick(); tick();
    chk("rundrop_valid", 32'(valid2), 32'h1);
    chk("rundrop_inst",  inst2, rom[1]);
    tick(); tick();
    chk("rundrop_hold",  32'(st2), 32'(HOLD));
    chk("rundrop_pc",    pc2, 32'd260);
    Inst_ready = 1'b1;
    tick();
    Inst_ready = 1'b0;
    chk("rundrop_idle", 32'(st2), 32'(IDLE));
    chk("rundrop_pc2",  pc2, 32'd264);

    // Load during FETCH aborts and restarts from the aligned address.
    Run = 1'b1;
    tick();
    Run = 1'b0;
    chk("ldf_state", 32'(st2), 32'(FETCH));
    Load = 1'b1; Load_addr = 32'h0000_0013;
    tick();
    Load = 1'b0;
    chk("ldf_pc",    pc2, 32'h10);
    chk("ldf_addr",  32'(rom_addr2), 32'h4);
    chk("ldf_state2", 32'(st2), 32'(FETCH));
    tick(); tick();
    chk("ldf_valid", 32'(valid2), 32'h1);
    chk("ldf_inst",  inst2, rom[4]);

    // Load in HOLD without ready: word dropped, back to IDLE at the new PC.
    Load = 1'b1; Load_addr = 32'h8;
    tick();
    Load = 1'b0;
    chk("ldh_pc",    pc2, 32'h8);
    chk("ldh_valid", 32'(valid2), 32'h0);
    chk("ldh_state", 32'(st2), 32'(IDLE));
    Step = 1'b0; tick(); Step = 1'b1;
    tick(); tick(); tick();
    chk("ldh_inst", inst2, rom[2]);
    chk("ldh_hold", 32'(st2), 32'(HOLD));

    // Load together with ready in HOLD: one transfer, PC takes Load_addr.
    Load = 1'b1; Load_addr = 32'h40; Inst_ready = 1'b1;
    tick();
    Load = 1'b0; Inst_ready = 1'b0;
    chk("ldx_pc",    pc2, 32'h40);
    chk("ldx_valid", 32'(valid2), 32'h0);
    chk("ldx_state", 32'(st2), 32'(IDLE));
    tick();
    chk("ldx_pc2",   pc2, 32'h40);
    chk("ldx_busy",  32'(busy2), 32'h0);

    // PC wrap at the top of the address space.
    Load = 1'b1; Load_addr = 32'hFFFF_FFFF;
    tick();
    Load = 1'b0;
    chk("wrap_pc",   pc2, 32'hFFFF_FFFC);
    chk("wrap_addr", 32'(rom_addr2), 32'd63);
    Step = 1'b0; tick(); Step = 1'b1;
    tick(); tick(); tick();
    chk("wrap_inst", inst2, rom[63]);
    Inst_ready = 1'b1;
    tick();
    Inst_ready = 1'b0;
    chk("wrap_pc0",  pc2, 32'h0);

    // Reset in the middle of a fetch.
    Load = 1'b1; Load_addr = 32'h20;
    tick();
    Load = 1'b0; Run = 1'b1;
    tick();
    chk("mid_busy", 32'(busy2), 32'h1);
    Rst = 1'b0; Run = 1'b0;
    tick();
    chk("mid_pc",    pc2, 32'h0);
    chk("mid_inst",  inst2, 32'h0);
    chk("mid_valid", 32'(valid2), 32'h0);
    chk("mid_busy0", 32'(busy2), 32'h0);
    chk("mid_state", 32'(st2), 32'(IDLE));
    Rst = 1'b1;
    tick(); tick();
    chk("mid_after", 32'(st2), 32'(IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
